// File: rtl/present_iter_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : present_iter_core                                            |
// | Description : Iterative PRESENT-80/128 cipher, one round per clock.        |
// |               Decryption (PRESENT_DEC_EN) rolls the key forward, then back.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module present_iter_core #(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic [KEY_W-1:0] in_key,
  input  logic             in_dec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             busy
);

  localparam logic [63:0] c_SBOX     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] c_SBOX_INV = 64'hA970364BD21C8FE5;
  localparam int          c_CTR_LSB  = (KEY_W == 128) ? 62 : 15;
  localparam logic [4:0]  c_LAST     = 5'(ROUNDS);

  if ((KEY_W != 80) && (KEY_W != 128)) begin : g_key_w_check
    $error("present_iter_core: KEY_W must be 80 or 128");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_KEXP = 3'd1,
    S_ENC  = 3'd2,
    S_DEC  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = c_SBOX[4*x[4*n +: 4] +: 4];
    return y;
  endfunction

  // Bit i moves to 16*i mod 63; bit 63 stays put.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 63; i++) y[(16*i) % 63] = x[i];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k, input logic [4:0] c);
    logic [KEY_W-1:0] t;
    t = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
    t[KEY_W-1 -: 4] = c_SBOX[4*t[KEY_W-1 -: 4] +: 4];
    if (KEY_W == 128) t[KEY_W-5 -: 4] = c_SBOX[4*t[KEY_W-5 -: 4] +: 4];
    t[c_CTR_LSB +: 5] = t[c_CTR_LSB +: 5] ^ c;
    return t;
  endfunction

`ifdef PRESENT_DEC_EN
  function automatic logic [63:0] s_inv_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = c_SBOX_INV[4*x[4*n +: 4] +: 4];
    return y;
  endfunction

  function automatic logic [63:0] p_inv_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 63; i++) y[i] = x[(16*i) % 63];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k, input logic [4:0] c);
    logic [KEY_W-1:0] t;
    t = k;
    t[c_CTR_LSB +: 5] = t[c_CTR_LSB +: 5] ^ c;
    t[KEY_W-1 -: 4] = c_SBOX_INV[4*t[KEY_W-1 -: 4] +: 4];
    if (KEY_W == 128) t[KEY_W-5 -: 4] = c_SBOX_INV[4*t[KEY_W-5 -: 4] +: 4];
    return {t[60:0], t[KEY_W-1:61]};
  endfunction
`endif

  state_t           r_fsm, w_fsm_nxt;
  logic [63:0]      r_state, w_state_nxt;
  logic [KEY_W-1:0] r_key, w_key_nxt;
  logic [4:0]       r_ctr, w_ctr_nxt;
  logic [63:0]      r_out, w_out_nxt;

  logic [63:0]      w_rk;
  logic [63:0]      w_enc_blk;
  logic [KEY_W-1:0] w_key_fwd;
  logic             w_accept;

  assign w_rk      = r_key[KEY_W-1 -: 64];
  assign w_enc_blk = p_layer(s_layer(r_state ^ w_rk));
  assign w_key_fwd = key_fwd(r_key, r_ctr);

`ifdef PRESENT_DEC_EN
  logic [63:0]      w_dec_blk;
  logic [KEY_W-1:0] w_key_inv;
  assign w_dec_blk = s_inv_layer(p_inv_layer(r_state ^ w_rk));
  assign w_key_inv = key_inv(r_key, r_ctr);
`else
  logic w_dec_unused;
  assign w_dec_unused = in_dec;
`endif

  // rst_n gating keeps in_ready low for the whole reset window.
  assign in_ready  = (r_fsm == S_IDLE) && rst_n;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_fsm == S_DONE);
  assign busy      = (r_fsm != S_IDLE);
  assign out_data  = r_out;

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_ctr_nxt   = r_ctr;
    w_out_nxt   = r_out;
    case (r_fsm)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = in_data;
          w_key_nxt   = in_key;
          w_ctr_nxt   = 5'd1;
`ifdef PRESENT_DEC_EN
          w_fsm_nxt   = in_dec ? S_KEXP : S_ENC;
`else
          w_fsm_nxt   = S_ENC;
`endif
        end
      end
      S_ENC: begin
        w_state_nxt = w_enc_blk;
        w_key_nxt   = w_key_fwd;
        if (r_ctr == c_LAST) begin
          w_out_nxt = w_enc_blk ^ w_key_fwd[KEY_W-1 -: 64];
          w_fsm_nxt = S_DONE;
        end else begin
          w_ctr_nxt = r_ctr + 5'd1;
        end
      end
`ifdef PRESENT_DEC_EN
      S_KEXP: begin
        w_key_nxt = w_key_fwd;
        // Counter parks at the last round so DEC can count straight back down.
        if (r_ctr == c_LAST) w_fsm_nxt = S_DEC;
        else                 w_ctr_nxt = r_ctr + 5'd1;
      end
      S_DEC: begin
        w_state_nxt = w_dec_blk;
        w_key_nxt   = w_key_inv;
        if (r_ctr == 5'd1) begin
          w_out_nxt = w_dec_blk ^ w_key_inv[KEY_W-1 -: 64];
          w_fsm_nxt = S_DONE;
        end else begin
          w_ctr_nxt = r_ctr - 5'd1;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= S_IDLE;
      r_state <= '0;
      r_key   <= '0;
      r_ctr   <= '0;
      r_out   <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_ctr   <= w_ctr_nxt;
      r_out   <= w_out_nxt;
    end
  end

endmodule
`default_nettype wire

// File: doc/present_iter_core.md
Name: present_iter_core

Overview:
- Iterative PRESENT block cipher engine: one round per clock, 64-bit block.
- Parametrised key width: PRESENT-80 or PRESENT-128.
- Encryption, plus optional decryption with an on-the-fly inverse key schedule.
- Sits between a valid/ready data source and sink. It replaces a combinational round chain with one registered round datapath plus an FSM.

Parameters:
- KEY_W, 80, key size in bits. Legal values are 80 and 128; any other value is an elaboration error.
- ROUNDS, 31, number of full rounds. Fixed by the cipher and exposed for bench use only.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  core can accept a request
- in_data  in  64  plaintext or ciphertext; bit 63 = leftmost cipher bit
- in_key  in  KEY_W  cipher key; bit KEY_W-1 = leftmost
- in_dec  in  1  1 = decrypt, 0 = encrypt; sampled with in_data
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- out_data  out  64  result block
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; state, key and counter registers clear.
  - in_ready=1 once reset deasserts.
  - out_valid=0, out_data=0, busy=0.
  - Reset mid-operation discards the job; no result is produced.
- FSM states: IDLE, KEXP, ENC, DEC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load state<=in_data, key<=in_key, ctr<=1.
  - Next state is ENC if in_dec=0, otherwise KEXP.
- Round key: rk = key[KEY_W-1 -: 64].
- Forward key update with counter c:
  - Rotate left 61.
  - Apply S-box to the top nibble. For KEY_W=128, also apply it to the next nibble (bits 123:120).
  - XOR c into bits 19:15 (KEY_W=80) or bits 66:62 (KEY_W=128).
- Inverse key update reverses these steps exactly: XOR c, then inverse S-box, then rotate right 61.
- ENC, one cycle per ctr = 1..31:
  - state <= P(S(state ^ rk)); key <= fwd_update(key, ctr).
  - On ctr=31, out_data <= P(S(state ^ rk)) ^ rk(fwd_update(key,31)), then go to DONE.
  - Latency: 31 cycles from accept edge to out_valid high.
- KEXP, ctr = 1..31:
  - key <= fwd_update(key, ctr). The state register holds.
  - After ctr=31, set ctr<=31 and go to DEC.
- DEC, ctr = 31 down to 1:
  - state <= invS(invP(state ^ rk)); key <= inv_update(key, ctr).
  - On ctr=1, out_data <= invS(invP(state ^ rk)) ^ rk(inv_update(key,1)), then go to DONE.
  - Decrypt latency: 62 cycles.
- DONE:
  - out_valid=1; out_data holds stable until out_valid&&out_ready.
  - On that handshake go to IDLE. out_valid drops the next cycle; out_data keeps its last value.
  - in_ready=0 in DONE. There is no accept on the same cycle as result drain. The first new accept is the cycle after drain.
- Backpressure: out_ready held low keeps the core in DONE indefinitely. No state or key register changes during that time.
- in_valid outside IDLE is ignored. Inputs are sampled only at the accept edge, so source changes afterwards have no effect.
- Counter is 5 bits. It never wraps: the range is 1..31 and the FSM exits before overflow.

Optional Feature:
- Macro: PRESENT_DEC_EN.
- Defined:
  - KEXP and DEC states exist, along with the inverse S-box, inverse P-layer and inverse key update.
  - in_dec selects the mode as described above.
- Undefined:
  - KEXP, DEC and the inverse logic are not synthesised.
  - in_dec is ignored and every request encrypts (31-cycle latency).
  - Port list is unchanged.

Test Plan:
- KEY_W=80, key=0, pt=0000000000000000, encrypt -> out_data=5579C1387B228445; out_valid high exactly 31 cycles after accept.
- KEY_W=80, key=all ones, pt=FFFFFFFFFFFFFFFF -> 3333DCD3213210D2. Same key, pt=0 -> E72C46C0F5945049. Key=0, pt=all ones -> A112FFC72F68417B.
- KEY_W=128, key=0, pt=0 -> 96DB702A2E6900AF.
- PRESENT_DEC_EN defined, KEY_W=80, key=0:
  - Decrypt ct=5579C1387B228445 -> 0000000000000000, out_valid 62 cycles after accept.
  - Repeat with the macro undefined: in_dec=1 yields the encryption result after 31 cycles.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_data stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> one handshake; in_ready=1 the next cycle.
- Async reset: assert rst_n=0 at round 10 -> immediately out_valid=0, busy=0, in_ready=0 while reset is held. After release, in_ready=1, and a fresh key=0/pt=0 encrypt returns 5579C1387B228445.
